hazard_ctrl_mc: RTL and testbench
=================================

# hazard_ctrl_mc

Parametrised pipeline hazard controller for the 5-stage MIPS core. It sits beside the D/E/M/W pipeline registers and drives their stall and flush controls. It combines load-use and branch-compare stall detection, register-0-aware E-stage and D-stage forwarding selects, and a multi-cycle multiply/divide occupancy FSM that holds the E stage. It also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- REG_AW, 5, register-address width
- MD_LATENCY, 4, total cycles a mul/div op occupies E (≥1)
- CNT_W, 16, stall-counter width

Ports (clock and reset first):
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- Rs_D, Rt_D  in  REG_AW  source registers in Decode
- Rs_E, Rt_E  in  REG_AW  source registers in Execute
- Write_Reg_E, Write_Reg_M, Write_Reg_W  in  REG_AW  destination registers per stage
- Reg_Write_E, Reg_Write_M, Reg_Write_W  in  1  register-write enables per stage
- MemtoReg_E, MemtoReg_M  in  1  load in E / M
- Branch_D  in  1  branch in Decode
- MD_Start_E  in  1  mul/div op present in Execute
- Stat_Clr  in  1  synchronous clear of Stall_Count
- Stall_F, Stall_D, Stall_E  out  1  hold F / D / E pipeline registers
- Flush_E, Flush_M  out  1  insert a bubble into E / M
- Forward_A_E, Forward_B_E  out  2  ALU operand select: 00 register file, 01 W, 10 M
- Forward_A_D, Forward_B_D  out  1  branch comparator takes the M result
- MD_Busy  out  1  FSM is in BUSY
- Stall_Count  out  CNT_W  cycles with Stall_F=1

## Operation
- A register match ("hit") requires equal addresses and a nonzero address. Register 0 never forwards and never stalls.
- Load-use stall: lwstall = MemtoReg_E & (hit(Rs_D,Rt_E) | hit(Rt_D,Rt_E)).
- Branch stall: brstall = Branch_D & ((Reg_Write_E & (hit(Rs_D,Write_Reg_E) | hit(Rt_D,Write_Reg_E))) | (MemtoReg_M & (hit(Rs_D,Write_Reg_M) | hit(Rt_D,Write_Reg_M)))).
- Forward_A_E selection, applied identically to Forward_B_E with Rt_E:
  - 10 if Reg_Write_M & hit(Rs_E,Write_Reg_M)
  - else 01 if Reg_Write_W & hit(Rs_E,Write_Reg_W)
  - else 00
  - M has priority over W.
- Forward_A_D = Reg_Write_M & hit(Rs_D,Write_Reg_M). Forward_B_D is the same with Rt_D.
- Mul/div FSM, states IDLE and BUSY, with a down-counter md_cnt:
  - IDLE & MD_Start_E & MD_LATENCY>1: md_stall=1, go to BUSY, md_cnt←MD_LATENCY−2.
  - BUSY & md_cnt≠0: md_stall=1, md_cnt decrements.
  - BUSY & md_cnt=0: md_stall=0, go to IDLE. MD_Start_E is ignored this cycle because it is the same op leaving E.
  - MD_LATENCY=1: the FSM never leaves IDLE and md_stall is always 0.
- Output priority:
  - md_stall=1: Stall_F=Stall_D=Stall_E=1, Flush_M=1, Flush_E=0. lw/branch stalls are masked because D is already held.
  - else lwstall|brstall: Stall_F=Stall_D=1, Flush_E=1, Stall_E=0, Flush_M=0.
  - else all stall/flush outputs are 0.
- Stall_Count increments each cycle Stall_F=1 and saturates at all-ones.
  - Stat_Clr zeroes it. If Stat_Clr and Stall_F are both 1 in the same cycle, the result is 0 (clear wins).

## Timing
- Forwarding and stall/flush outputs are combinational from inputs and FSM state, with zero latency.
- FSM state, md_cnt and Stall_Count update on the clk rising edge.
- A mul/div op stays in E for exactly MD_LATENCY cycles, with MD_LATENCY−1 stall cycles.
- Back-to-back mul/div: the second op enters E the cycle after the BUSY→IDLE cycle and restarts the sequence.
- Reset (async, any time including mid-BUSY): state=IDLE, md_cnt=0, Stall_Count=0. All outputs then follow the inputs combinationally, with MD_Busy=0.

## Structure
- Package hazard_pkg holds:
  - forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - the md_state_t enum {IDLE, BUSY}
- One sub-module, md_occupancy (FSM plus md_cnt), parametrised by MD_LATENCY, outputs md_stall and MD_Busy. The top level holds the comparators, priority logic and the counter.

## Test plan
- Load-use: MemtoReg_E=1, Rt_E=8, Rs_D=8 → Stall_F=Stall_D=Flush_E=1, Stall_E=0. Repeat with Rt_E=0, Rs_D=0 → all stall/flush outputs 0.
- Forwarding priority: Rs_E=5, Write_Reg_M=5, Write_Reg_W=5, both Reg_Write=1 → Forward_A_E=10. Drop Reg_Write_M → 01. Rs_E=0 → 00.
- Branch stall: Branch_D=1, Reg_Write_E=1, Write_Reg_E=3, Rt_D=3 → stall. Move the producer to M as an ALU op (MemtoReg_M=0) → no stall and Forward_B_D=1.
- Mul/div, MD_LATENCY=4: MD_Start_E held for 4 cycles → Stall_E/Flush_M high for 3 cycles, MD_Busy high for cycles 2–4, and an overlapping lwstall produces Flush_E=0 throughout.
- Reset asserted while BUSY with md_cnt=1 → MD_Busy=0 immediately (async) and Stall_Count=0. After release, a new MD_Start_E gets a full 4-cycle occupancy.
- Counter with CNT_W=4: 20 stall cycles → Stall_Count=15 (saturated). Stat_Clr and Stall_F together → 0 on the next cycle.

Source files
------------

// File: rtl/hazard_ctrl_mc_pkg.sv
// Shared constants and types for the pipeline hazard controller.
// Holds the forwarding-select encodings and the mul/div occupancy FSM state type.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/hazard_ctrl_mc_md_occupancy.sv
// Mul/div occupancy tracker: keeps the Execute stage held for MD_LATENCY cycles per op.
// The stall request is combinational from state and start; busy is a registered flag.
module md_occupancy
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  output logic o_md_stall,
  output logic o_md_busy
);

  localparam int CW = (MD_LATENCY > 2) ? $clog2(MD_LATENCY - 1) : 1;
  localparam bit MULTI = (MD_LATENCY > 1);
  localparam logic [CW-1:0] LOAD = MULTI ? CW'(MD_LATENCY - 2) : '0;

  md_state_t       r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;

  // The final BUSY cycle (count at zero) releases the stall; a start seen then is the same op.
  assign o_md_stall = (r_state == IDLE) ? (MULTI && i_start) : (r_cnt != '0);
  assign o_md_busy  = r_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (MULTI && i_start) begin
            r_state <= BUSY;
            r_cnt   <= LOAD;
            r_busy  <= 1'b1;
          end
        end
        BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Pipeline hazard controller for the 5-stage MIPS core: stall/flush generation,
// E- and D-stage forwarding selects, mul/div occupancy and a saturating stall counter.
module hazard_ctrl_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs_D,
  input  logic [REG_AW-1:0] Rt_D,
  input  logic [REG_AW-1:0] Rs_E,
  input  logic [REG_AW-1:0] Rt_E,
  input  logic [REG_AW-1:0] Write_Reg_E,
  input  logic [REG_AW-1:0] Write_Reg_M,
  input  logic [REG_AW-1:0] Write_Reg_W,
  input  logic              Reg_Write_E,
  input  logic              Reg_Write_M,
  input  logic              Reg_Write_W,
  input  logic              MemtoReg_E,
  input  logic              MemtoReg_M,
  input  logic              Branch_D,
  input  logic              MD_Start_E,
  input  logic              Stat_Clr,
  output logic              Stall_F,
  output logic              Stall_D,
  output logic              Stall_E,
  output logic              Flush_E,
  output logic              Flush_M,
  output logic [1:0]        Forward_A_E,
  output logic [1:0]        Forward_B_E,
  output logic              Forward_A_D,
  output logic              Forward_B_D,
  output logic              MD_Busy,
  output logic [CNT_W-1:0]  Stall_Count
);

  // Register 0 is hardwired to zero, so it can never be a real dependency.
  function automatic logic hit(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
    return (a == b) && (a != '0);
  endfunction

  logic             w_lwstall;
  logic             w_brstall;
  logic             w_md_stall;
  logic [CNT_W-1:0] r_stall_count;

  md_occupancy #(
    .MD_LATENCY (MD_LATENCY)
  ) u_md_occupancy (
    .clk        (clk),
    .reset      (reset),
    .i_start    (MD_Start_E),
    .o_md_stall (w_md_stall),
    .o_md_busy  (MD_Busy)
  );

  assign w_lwstall = MemtoReg_E & (hit(Rs_D, Rt_E) | hit(Rt_D, Rt_E));
  assign w_brstall = Branch_D &
                     ((Reg_Write_E & (hit(Rs_D, Write_Reg_E) | hit(Rt_D, Write_Reg_E))) |
                      (MemtoReg_M  & (hit(Rs_D, Write_Reg_M) | hit(Rt_D, Write_Reg_M))));

  assign Forward_A_D = Reg_Write_M & hit(Rs_D, Write_Reg_M);
  assign Forward_B_D = Reg_Write_M & hit(Rt_D, Write_Reg_M);

  always_comb begin
    Forward_A_E = FWD_RF;
    Forward_B_E = FWD_RF;
    if (Reg_Write_M && hit(Rs_E, Write_Reg_M))      Forward_A_E = FWD_MEM;
    else if (Reg_Write_W && hit(Rs_E, Write_Reg_W)) Forward_A_E = FWD_WB;
    if (Reg_Write_M && hit(Rt_E, Write_Reg_M))      Forward_B_E = FWD_MEM;
    else if (Reg_Write_W && hit(Rt_E, Write_Reg_W)) Forward_B_E = FWD_WB;
  end

  // A mul/div hold already freezes D, so lw/branch stalls are masked underneath it.
  always_comb begin
    Stall_F = 1'b0;
    Stall_D = 1'b0;
    Stall_E = 1'b0;
    Flush_E = 1'b0;
    Flush_M = 1'b0;
    if (w_md_stall) begin
      Stall_F = 1'b1;
      Stall_D = 1'b1;
      Stall_E = 1'b1;
      Flush_M = 1'b1;
    end else if (w_lwstall || w_brstall) begin
      Stall_F = 1'b1;
      Stall_D = 1'b1;
      Flush_E = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (Stat_Clr) begin
      r_stall_count <= '0;
    end else if (Stall_F && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  assign Stall_Count = r_stall_count;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed testbench for hazard_ctrl_mc (MD_LATENCY=4, CNT_W=4) with hand-computed expectations.
module tb_hazard_ctrl_mc;

  typedef struct packed {
    logic [4:0] rsD;
    logic [4:0] rtD;
    logic [4:0] rsE;
    logic [4:0] rtE;
    logic [4:0] wrE;
    logic [4:0] wrM;
    logic [4:0] wrW;
    logic       rwE;
    logic       rwM;
    logic       rwW;
    logic       memE;
    logic       memM;
    logic       branchD;
    logic       mdStart;
    logic       statClr;
  } stim_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs_D, Rt_D, Rs_E, Rt_E, Write_Reg_E, Write_Reg_M, Write_Reg_W;
  logic       Reg_Write_E, Reg_Write_M, Reg_Write_W, MemtoReg_E, MemtoReg_M;
  logic       Branch_D, MD_Start_E, Stat_Clr;
  logic       Stall_F, Stall_D, Stall_E, Flush_E, Flush_M;
  logic [1:0] Forward_A_E, Forward_B_E;
  logic       Forward_A_D, Forward_B_D, MD_Busy;
  logic [3:0] Stall_Count;

  int vectorsApplied = 0;
  int miscompares    = 0;

  hazard_ctrl_mc #(
    .REG_AW     (5),
    .MD_LATENCY (4),
    .CNT_W      (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Rs_D        (Rs_D),
    .Rt_D        (Rt_D),
    .Rs_E        (Rs_E),
    .Rt_E        (Rt_E),
    .Write_Reg_E (Write_Reg_E),
    .Write_Reg_M (Write_Reg_M),
    .Write_Reg_W (Write_Reg_W),
    .Reg_Write_E (Reg_Write_E),
    .Reg_Write_M (Reg_Write_M),
    .Reg_Write_W (Reg_Write_W),
    .MemtoReg_E  (MemtoReg_E),
    .MemtoReg_M  (MemtoReg_M),
    .Branch_D    (Branch_D),
    .MD_Start_E  (MD_Start_E),
    .Stat_Clr    (Stat_Clr),
    .Stall_F     (Stall_F),
    .Stall_D     (Stall_D),
    .Stall_E     (Stall_E),
    .Flush_E     (Flush_E),
    .Flush_M     (Flush_M),
    .Forward_A_E (Forward_A_E),
    .Forward_B_E (Forward_B_E),
    .Forward_A_D (Forward_A_D),
    .Forward_B_D (Forward_B_D),
    .MD_Busy     (MD_Busy),
    .Stall_Count (Stall_Count)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input stim_t s);
    Rs_D        = s.rsD;
    Rt_D        = s.rtD;
    Rs_E        = s.rsE;
    Rt_E        = s.rtE;
    Write_Reg_E = s.wrE;
    Write_Reg_M = s.wrM;
    Write_Reg_W = s.wrW;
    Reg_Write_E = s.rwE;
    Reg_Write_M = s.rwM;
    Reg_Write_W = s.rwW;
    MemtoReg_E  = s.memE;
    MemtoReg_M  = s.memM;
    Branch_D    = s.branchD;
    MD_Start_E  = s.mdStart;
    Stat_Clr    = s.statClr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorsApplied++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after the falling edge, well clear of the rising edge.
  task automatic nextWindow();
    @(negedge clk);
    #1;
  endtask

  stim_t s;
  stim_t idle;
  stim_t lw;

  initial begin
    idle = '0;
    lw = '0;
    lw.memE = 1'b1;
    lw.rtE  = 5'd8;
    lw.rsD  = 5'd8;

    reset = 1'b1;
    applyStimulus(idle);
    #2;
    checkOutput("reset_busy", 32'(MD_Busy), 32'd0);
    checkOutput("reset_count", 32'(Stall_Count), 32'd0);
    checkOutput("reset_stallF", 32'(Stall_F), 32'd0);
    nextWindow();
    reset = 1'b0;

    nextWindow();
    applyStimulus(lw);
    #1;
    checkOutput("lw_stallF", 32'(Stall_F), 32'd1);
    checkOutput("lw_stallD", 32'(Stall_D), 32'd1);
    checkOutput("lw_flushE", 32'(Flush_E), 32'd1);
    checkOutput("lw_stallE", 32'(Stall_E), 32'd0);
    checkOutput("lw_flushM", 32'(Flush_M), 32'd0);
    applyStimulus(idle);

    nextWindow();
    s = lw; s.rtE = 5'd0; s.rsD = 5'd0;
    applyStimulus(s);
    #1;
    checkOutput("lw_r0_stallF", 32'(Stall_F), 32'd0);
    checkOutput("lw_r0_flushE", 32'(Flush_E), 32'd0);
    applyStimulus(idle);

    nextWindow();
    s = idle; s.rsE = 5'd5; s.rtE = 5'd5; s.wrM = 5'd5; s.wrW = 5'd5; s.rwM = 1'b1; s.rwW = 1'b1;
    applyStimulus(s);
    #1;
    checkOutput("fwdA_mem", 32'(Forward_A_E), 32'd2);
    checkOutput("fwdB_mem", 32'(Forward_B_E), 32'd2);
    s.rwM = 1'b0;
    applyStimulus(s);
    #1;
    checkOutput("fwdA_wb", 32'(Forward_A_E), 32'd1);
    s.rsE = 5'd0; s.wrM = 5'd0; s.wrW = 5'd0; s.rwM = 1'b1;
    applyStimulus(s);
    #1;
    checkOutput("fwdA_r0", 32'(Forward_A_E), 32'd0);
    applyStimulus(idle);

    nextWindow();
    s = idle; s.branchD = 1'b1; s.rwE = 1'b1; s.wrE = 5'd3; s.rtD = 5'd3;
    applyStimulus(s);
    #1;
    checkOutput("br_E_stallF", 32'(Stall_F), 32'd1);
    checkOutput("br_E_flushE", 32'(Flush_E), 32'd1);
    s = idle; s.branchD = 1'b1; s.rwM = 1'b1; s.wrM = 5'd3; s.rtD = 5'd3;
    applyStimulus(s);
    #1;
    checkOutput("br_Malu_stallF", 32'(Stall_F), 32'd0);
    checkOutput("br_Malu_fwdBD", 32'(Forward_B_D), 32'd1);
    checkOutput("br_Malu_fwdAD", 32'(Forward_A_D), 32'd0);
    s.memM = 1'b1;
    applyStimulus(s);
    #1;
    checkOutput("br_Mload_stallF", 32'(Stall_F), 32'd1);
    applyStimulus(idle);

    nextWindow();
    checkOutput("count_after_comb", 32'(Stall_Count), 32'd0);

    // Four-cycle mul/div with an overlapping load-use on its stall cycles.
    for (int i = 0; i < 4; i++) begin
      nextWindow();
      s = (i < 3) ? lw : idle;
      s.mdStart = 1'b1;
      applyStimulus(s);
      #1;
      checkOutput($sformatf("md_stallE_%0d", i), 32'(Stall_E), (i < 3) ? 32'd1 : 32'd0);
      checkOutput($sformatf("md_flushM_%0d", i), 32'(Flush_M), (i < 3) ? 32'd1 : 32'd0);
      checkOutput($sformatf("md_busy_%0d", i), 32'(MD_Busy), (i > 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("md_flushE_%0d", i), 32'(Flush_E), 32'd0);
    end
    nextWindow();
    applyStimulus(idle);
    #1;
    checkOutput("md_done_busy", 32'(MD_Busy), 32'd0);
    checkOutput("md_done_count", 32'(Stall_Count), 32'd3);

    s = idle; s.mdStart = 1'b1;
    nextWindow();
    applyStimulus(s);
    nextWindow();
    nextWindow();
    applyStimulus(idle);
    #1;
    checkOutput("midbusy_busy", 32'(MD_Busy), 32'd1);
    checkOutput("midbusy_stallE", 32'(Stall_E), 32'd1);
    checkOutput("midbusy_count", 32'(Stall_Count), 32'd5);
    reset = 1'b1;
    #1;
    checkOutput("async_rst_busy", 32'(MD_Busy), 32'd0);
    checkOutput("async_rst_count", 32'(Stall_Count), 32'd0);
    checkOutput("async_rst_stallF", 32'(Stall_F), 32'd0);
    nextWindow();
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      nextWindow();
      applyStimulus(s);
      #1;
      checkOutput($sformatf("md2_stallE_%0d", i), 32'(Stall_E), (i < 3) ? 32'd1 : 32'd0);
      checkOutput($sformatf("md2_busy_%0d", i), 32'(MD_Busy), (i > 0) ? 32'd1 : 32'd0);
    end
    nextWindow();
    applyStimulus(idle);
    #1;
    checkOutput("md2_done_busy", 32'(MD_Busy), 32'd0);
    checkOutput("md2_done_count", 32'(Stall_Count), 32'd3);

    s = idle; s.statClr = 1'b1;
    applyStimulus(s);
    nextWindow();
    checkOutput("clr_count", 32'(Stall_Count), 32'd0);
    applyStimulus(lw);
    repeat (10) nextWindow();
    checkOutput("count_10", 32'(Stall_Count), 32'd10);
    repeat (10) nextWindow();
    checkOutput("count_sat", 32'(Stall_Count), 32'd15);
    s = lw; s.statClr = 1'b1;
    applyStimulus(s);
    #1;
    checkOutput("clr_with_stall_stallF", 32'(Stall_F), 32'd1);
    nextWindow();
    checkOutput("clr_wins", 32'(Stall_Count), 32'd0);
    applyStimulus(lw);
    nextWindow();
    checkOutput("count_after_clr", 32'(Stall_Count), 32'd1);
    applyStimulus(idle);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
